// File: rtl/dpsk_dly_demod.sv
`timescale 1ns/1ps
// dpsk_dly_demod
// Delay-and-multiply (D)PSK demodulator for the ADC capture path.
//   Stage p0 : offset-binary -> signed conversion, circular delay-line write/read, priming check
//   Stage p1 : mixer product s * s_delayed, scaled by 2^-(DATA_W-1) and saturated
//   Stage p2 : integrate-and-dump over DEC mixer outputs (decimation)
//   Stage p3 : AVG_LEN-tap moving average, DC (avr_data_o) / AC (ac_data_o) split
//   Stage p4 : optional hysteresis slicer, compiled in when DPSK_SLICER_EN is defined
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous clear, same effect as reset, wins over din_valid_i
//   data_in_i    offset-binary ADC sample, qualified by din_valid_i
//   delay_sel_i  mixer delay in samples, clamped to [1, MAX_DELAY]; any change re-primes
//   mix_o        signed mixer product, mix_valid_o pulses per primed sample
//   ds_mix_o     signed decimated output, ds_valid_o pulses per DEC mixer outputs
//   avr_data_o   moving average of ds_mix_o, ac_data_o = sat(ds_mix_o - avr_data_o), ac_valid_o
//   bit_out_o    sliced bit with bit_valid_o (tied 0 unless DPSK_SLICER_EN is defined)
module dpsk_dly_demod #(
   parameter int DATA_W    = 12,
   parameter int MAX_DELAY = 128,
   parameter int DEC       = 16,
   parameter int AVG_LEN   = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           clear_i,
   input  logic        [DATA_W-1:0]       data_in_i,
   input  logic                           din_valid_i,
   input  logic        [$clog2(MAX_DELAY):0] delay_sel_i,
   output logic signed [DATA_W-1:0]       mix_o,
   output logic                           mix_valid_o,
   output logic signed [DATA_W-1:0]       ds_mix_o,
   output logic                           ds_valid_o,
   output logic signed [DATA_W-1:0]       avr_data_o,
   output logic signed [DATA_W-1:0]       ac_data_o,
   output logic                           ac_valid_o,
   output logic                           bit_out_o,
   output logic                           bit_valid_o
);
   localparam int AW     = $clog2(MAX_DELAY);
   localparam int SW     = AW + 1;
   localparam int DEC_SH = $clog2(DEC);
   localparam int AVG_SH = $clog2(AVG_LEN);
   localparam int ACC_W  = DATA_W + DEC_SH;
   localparam int SUM_W  = DATA_W + AVG_SH;
   localparam int PW     = 2 * DATA_W;
   localparam logic signed [PW-1:0] MAXP = PW'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [PW-1:0] MINP = -PW'(2 ** (DATA_W - 1));

   // Saturate a one-bit-wider signed value to DATA_W.
   function automatic logic signed [DATA_W-1:0] sat_w(input logic signed [DATA_W:0] x);
      if (x[DATA_W] != x[DATA_W-1])
         return x[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      return x[DATA_W-1:0];
   endfunction

   // Scale the full product back to DATA_W; only (-FS)*(-FS) can overflow.
   function automatic logic signed [DATA_W-1:0] mix_scale(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] sh;
      sh = p >>> (DATA_W - 1);
      if (sh > MAXP) return MAXP[DATA_W-1:0];
      if (sh < MINP) return MINP[DATA_W-1:0];
      return sh[DATA_W-1:0];
   endfunction

   typedef struct packed {
      logic        [SW-1:0]     dsel;
      logic        [AW-1:0]     wr_ptr;
      logic        [SW-1:0]     prime_cnt;
      logic                     vld_p0;
      logic signed [DATA_W-1:0] mix;
      logic                     mix_vld;
      logic signed [ACC_W-1:0]  acc;
      logic        [DEC_SH-1:0] phase;
      logic signed [DATA_W-1:0] ds;
      logic                     ds_vld;
      logic signed [SUM_W-1:0]  sum;
      logic        [AVG_SH:0]   fill;
      logic        [AVG_SH-1:0] aptr;
      logic signed [DATA_W-1:0] avr;
      logic signed [DATA_W-1:0] ac;
      logic                     ac_vld;
`ifdef DPSK_SLICER_EN
      logic                     bit_val;
      logic                     bit_vld;
`endif
   } ctrl_t;

   ctrl_t ctrl_q, ctrl_d;

   logic signed [DATA_W-1:0] dline_q [MAX_DELAY];
   logic signed [DATA_W-1:0] ring_q  [AVG_LEN];
   logic signed [DATA_W-1:0] s_p0_q, sd_p0_q;

   logic        [SW-1:0]     dly, prime_base;
   logic        [AW-1:0]     rd_addr;
   logic                     reprime, accept, primed;
   logic signed [DATA_W-1:0] s_d, oldest, avr_nxt, ac_nxt;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [SUM_W-1:0]  sum_nxt;

`ifdef DPSK_SLICER_EN
   localparam logic signed [DATA_W-1:0] H     = DATA_W'(2 ** (DATA_W - 4));
   localparam logic signed [DATA_W-1:0] NEG_H = -H;
`endif

   always_comb begin
      dly = delay_sel_i;
      if (delay_sel_i == '0) dly = SW'(1);
      else if (delay_sel_i > SW'(MAX_DELAY)) dly = SW'(MAX_DELAY);
      // D == MAX_DELAY wraps onto wr_ptr itself: the slot read is the one about to be overwritten.
      rd_addr    = ctrl_q.wr_ptr - dly[AW-1:0];
      reprime    = (delay_sel_i != ctrl_q.dsel);
      accept     = din_valid_i & ~clear_i;
      prime_base = reprime ? '0 : ctrl_q.prime_cnt;
      primed     = (prime_base >= dly);
      s_d        = {~data_in_i[DATA_W-1], data_in_i[DATA_W-2:0]};
      prod       = PW'(s_p0_q) * PW'(sd_p0_q);
      acc_sum    = ctrl_q.acc + ACC_W'($signed(ctrl_q.mix));
      // Unfilled window slots count as zero, which is what a zero-filled ring would hold.
      oldest     = ctrl_q.fill[AVG_SH] ? ring_q[ctrl_q.aptr] : '0;
      sum_nxt    = ctrl_q.sum + SUM_W'($signed(ctrl_q.ds)) - SUM_W'(oldest);
      avr_nxt    = sum_nxt[SUM_W-1:AVG_SH];
      ac_nxt     = sat_w((DATA_W+1)'($signed(ctrl_q.ds)) - (DATA_W+1)'(avr_nxt));

      ctrl_d = ctrl_q;

      // stage p0
      ctrl_d.dsel      = delay_sel_i;
      ctrl_d.vld_p0    = accept & primed;
      ctrl_d.prime_cnt = prime_base;
      if (accept) begin
         ctrl_d.wr_ptr = ctrl_q.wr_ptr + AW'(1);
         if (prime_base != SW'(MAX_DELAY)) ctrl_d.prime_cnt = prime_base + SW'(1);
      end

      // stage p1
      ctrl_d.mix_vld = ctrl_q.vld_p0;
      if (ctrl_q.vld_p0) ctrl_d.mix = mix_scale(prod);

      // stage p2
      ctrl_d.ds_vld = 1'b0;
      if (reprime) begin
         ctrl_d.acc   = '0;
         ctrl_d.phase = '0;
      end else if (ctrl_q.mix_vld) begin
         if (&ctrl_q.phase) begin
            ctrl_d.ds     = acc_sum[ACC_W-1:DEC_SH];
            ctrl_d.ds_vld = 1'b1;
            ctrl_d.acc    = '0;
            ctrl_d.phase  = '0;
         end else begin
            ctrl_d.acc   = acc_sum;
            ctrl_d.phase = ctrl_q.phase + DEC_SH'(1);
         end
      end

      // stage p3
      ctrl_d.ac_vld = ctrl_q.ds_vld;
      if (ctrl_q.ds_vld) begin
         ctrl_d.sum  = sum_nxt;
         ctrl_d.avr  = avr_nxt;
         ctrl_d.ac   = ac_nxt;
         ctrl_d.aptr = ctrl_q.aptr + AVG_SH'(1);
         if (!ctrl_q.fill[AVG_SH]) ctrl_d.fill = ctrl_q.fill + (AVG_SH+1)'(1);
      end

`ifdef DPSK_SLICER_EN
      // stage p4
      ctrl_d.bit_vld = ctrl_q.ac_vld;
      if (ctrl_q.ac_vld) begin
         if (ctrl_q.ac > H) ctrl_d.bit_val = 1'b1;
         else if (ctrl_q.ac < NEG_H) ctrl_d.bit_val = 1'b0;
      end
`endif

      if (clear_i) ctrl_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ctrl_q <= '0;
      else         ctrl_q <= ctrl_d;
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         dline_q[ctrl_q.wr_ptr] <= s_d;
         s_p0_q                 <= s_d;
         sd_p0_q                <= dline_q[rd_addr];
      end
      if (ctrl_q.ds_vld && !clear_i) ring_q[ctrl_q.aptr] <= ctrl_q.ds;
   end

   assign mix_o       = ctrl_q.mix;
   assign mix_valid_o = ctrl_q.mix_vld;
   assign ds_mix_o    = ctrl_q.ds;
   assign ds_valid_o  = ctrl_q.ds_vld;
   assign avr_data_o  = ctrl_q.avr;
   assign ac_data_o   = ctrl_q.ac;
   assign ac_valid_o  = ctrl_q.ac_vld;
`ifdef DPSK_SLICER_EN
   assign bit_out_o   = ctrl_q.bit_val;
   assign bit_valid_o = ctrl_q.bit_vld;
`else
   assign bit_out_o   = 1'b0;
   assign bit_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_dpsk_dly_demod.sv
`timescale 1ns/1ps
// Scoreboard bench for dpsk_dly_demod: a behavioural model predicts every mixer,
// decimator, moving-average and slicer output; a monitor compares on each valid pulse.
module tb_dpsk_dly_demod;
   localparam int DW   = 12;
   localparam int MAXD = 128;
   localparam int DEC  = 16;
   localparam int AVG  = 64;
   localparam int SW   = 8;
   localparam int FS   = 1 << (DW - 1);
   localparam int H    = 1 << (DW - 4);

   logic                 clk = 1'b0;
   logic                 rst_n, clear, din_valid;
   logic        [DW-1:0] data_in;
   logic        [SW-1:0] delay_sel;
   logic signed [DW-1:0] mix, ds_mix, avr_data, ac_data;
   logic                 mix_valid, ds_valid, ac_valid, bit_out, bit_valid;

   dpsk_dly_demod #(.DATA_W(DW), .MAX_DELAY(MAXD), .DEC(DEC), .AVG_LEN(AVG)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_in_i(data_in),
      .din_valid_i(din_valid), .delay_sel_i(delay_sel),
      .mix_o(mix), .mix_valid_o(mix_valid), .ds_mix_o(ds_mix), .ds_valid_o(ds_valid),
      .avr_data_o(avr_data), .ac_data_o(ac_data), .ac_valid_o(ac_valid),
      .bit_out_o(bit_out), .bit_valid_o(bit_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_fail = 0, bit_pulses = 0;
   int q_mix[$], q_mix_c[$], q_ds[$], q_avr[$], q_ac[$], q_bit[$];
   int hist[$], win[$];
   int prime, dec_sum, dec_n, slc, cur_sel;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sat(input int x);
      if (x > FS - 1) return FS - 1;
      if (x < -FS) return -FS;
      return x;
   endfunction

   function automatic int clamp_sel(input int v);
      if (v < 1) return 1;
      if (v > MAXD) return MAXD;
      return v;
   endfunction

   // ---------------- reference model ----------------
   task automatic model_reset();
      hist.delete(); win.delete();
      repeat (AVG) win.push_back(0);
      prime = 0; dec_sum = 0; dec_n = 0; slc = 0;
      q_mix.delete(); q_mix_c.delete(); q_ds.delete();
      q_avr.delete(); q_ac.delete(); q_bit.delete();
   endtask

   task automatic model_avg(input int ds);
      int total, avr, ac;
      void'(win.pop_front());
      win.push_back(ds);
      total = 0;
      foreach (win[k]) total += win[k];
      avr = total >>> 6;                // floor(total / AVG)
      ac  = sat(ds - avr);
      q_avr.push_back(avr);
      q_ac.push_back(ac);
      if (ac > H) slc = 1;
      else if (ac < -H) slc = 0;
      q_bit.push_back(slc);
   endtask

   task automatic model_sample(input int raw);
      int s, d, m;
      s = raw - FS;
      d = clamp_sel(cur_sel);
      if (prime >= d) begin
         m = sat((s * hist[hist.size() - d]) >>> (DW - 1));
         q_mix.push_back(m);
         q_mix_c.push_back(cyc + 2);
         dec_sum += m;
         dec_n++;
         if (dec_n == DEC) begin
            q_ds.push_back(dec_sum >>> 4); // floor(sum / DEC)
            model_avg(dec_sum >>> 4);
            dec_sum = 0;
            dec_n = 0;
         end
      end
      hist.push_back(s);
      if (prime < MAXD) prime++;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step(input bit v, input int d);
      din_valid = v;
      data_in   = DW'(d);
      if (v) model_sample(d);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0);
   endtask

   task automatic set_sel(input int v);
      idle(6);
      if (v != cur_sel) begin
         prime = 0; dec_sum = 0; dec_n = 0;
      end
      cur_sel   = v;
      delay_sel = SW'(v);
      idle(1);
   endtask

   task automatic rand_run(input int n, input int reset_at);
      for (int i = 0; i < n; i++) begin
         if (i == reset_at) begin
            din_valid = 1'b0;
            #2 rst_n = 1'b0;
            #1 check_zero("async_rst");
            model_reset();
            @(posedge clk); @(posedge clk); #1;
            rst_n = 1'b1;
            idle(1);
         end
         step(1'b1, int'($urandom_range(0, 4095)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 5)));
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_mix"}, int'(mix), 0);
      chk({tag, "_mix_valid"}, int'(mix_valid), 0);
      chk({tag, "_ds_mix"}, int'(ds_mix), 0);
      chk({tag, "_ds_valid"}, int'(ds_valid), 0);
      chk({tag, "_avr"}, int'(avr_data), 0);
      chk({tag, "_ac"}, int'(ac_data), 0);
      chk({tag, "_ac_valid"}, int'(ac_valid), 0);
      chk({tag, "_bit_out"}, int'(bit_out), 0);
      chk({tag, "_bit_valid"}, int'(bit_valid), 0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (mix_valid) begin
            if (q_mix.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL mix_extra: got mix_valid with mix=%0d, expected no output", mix);
            end else begin
               chk("mix", int'(mix), q_mix.pop_front());
               chk("mix_latency_cycle", cyc, q_mix_c.pop_front());
            end
         end
         if (ds_valid) begin
            if (q_ds.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL ds_extra: got ds_valid with ds_mix=%0d, expected no output", ds_mix);
            end else chk("ds_mix", int'(ds_mix), q_ds.pop_front());
         end
         if (ac_valid) begin
            if (q_ac.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL ac_extra: got ac_valid with ac=%0d, expected no output", ac_data);
            end else begin
               chk("avr_data", int'(avr_data), q_avr.pop_front());
               chk("ac_data", int'(ac_data), q_ac.pop_front());
            end
         end
         if (bit_valid) begin
`ifdef DPSK_SLICER_EN
            if (q_bit.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL bit_extra: got bit_valid with bit=%0d, expected no output", bit_out);
            end else chk("bit_out", int'(bit_out), q_bit.pop_front());
`else
            bit_pulses++;
`endif
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish by 1 ms, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0; clear = 1'b0; din_valid = 1'b0; data_in = '0;
      delay_sel = SW'(80); cur_sel = 80;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // constant 3072 at delay 80: mix 512, ds 512, average settles
      for (int i = 0; i < 81 + 16 * 70; i++) step(1'b1, 3072);

      // negative full scale squared saturates
      set_sel(1);
      for (int i = 0; i < 40; i++) step(1'b1, 0);

      // alternating pattern, delay 1 then 2
      set_sel(1);
      for (int i = 0; i < 48; i++) step(1'b1, (i % 2) ? 1024 : 3072);
      set_sel(2);
      for (int i = 0; i < 48; i++) step(1'b1, (i % 2) ? 1024 : 3072);

      // clamped delays with random data and random gaps
      set_sel(0);
      rand_run(300, -1);
      set_sel(200);
      rand_run(400, -1);

      // clear together with a valid sample: sample dropped, priming restarts
      idle(6);
      clear = 1'b1; din_valid = 1'b1; data_in = DW'(555);
      model_reset();
      @(posedge clk); #1;
      clear = 1'b0; din_valid = 1'b0;
      check_zero("clear");

      set_sel(5);
      rand_run(400, 150);
      set_sel(128);
      rand_run(250, -1);

      idle(30);
      chk("mix_pending", q_mix.size(), 0);
      chk("ds_pending", q_ds.size(), 0);
      chk("ac_pending", q_ac.size(), 0);
`ifdef DPSK_SLICER_EN
      chk("bit_pending", q_bit.size(), 0);
`else
      chk("bit_valid_pulses", bit_pulses, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
